// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the execute-stage load/store unit.
// Holds the op encoding, access size, tracking-FIFO entry layout and the
// small decode functions used by exu_lsu.
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'd0,
      OP_LH  = 4'd1,
      OP_LW  = 4'd2,
      OP_LD  = 4'd3,
      OP_LBU = 4'd4,
      OP_LHU = 4'd5,
      OP_LWU = 4'd6,
      OP_SB  = 4'd7,
      OP_SH  = 4'd8,
      OP_SW  = 4'd9,
      OP_SD  = 4'd10
   } lsu_op_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_t;

   // Entry fields are sized for the widest configuration (64-bit data,
   // up to 8-bit register index); narrower builds zero-extend into them.
   localparam int LSU_OFF_MAX_W = 3;
   localparam int LSU_RD_MAX_W  = 8;

   typedef struct packed {
      logic                    is_load;
      size_t                   size;
      logic                    is_signed;
      logic [LSU_OFF_MAX_W-1:0] off;
      logic [LSU_RD_MAX_W-1:0]  rd;
   } lsu_entry_t;

   function automatic size_t op_size(input lsu_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_B;
         OP_LH, OP_LHU, OP_SH: return SZ_H;
         OP_LW, OP_LWU, OP_SW: return SZ_W;
         default:              return SZ_D;
      endcase
   endfunction

   function automatic logic op_is_load(input lsu_op_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
   endfunction

   function automatic logic op_is_signed(input lsu_op_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD};
   endfunction

   // Unused encodings of the 4-bit op field are rejected like illegal ops.
   function automatic logic op_is_known(input lsu_op_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
                        OP_SB, OP_SH, OP_SW, OP_SD};
   endfunction

   // Byte-enable pattern for an 8-lane bus; narrower buses keep the low lanes.
   function automatic logic [7:0] be_mask(input size_t size, input logic [2:0] off);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

endpackage

// File: rtl/lsu_fifo.sv
// Small synchronous FIFO tracking outstanding bus transactions.
// Head entry is visible combinationally so a response can be matched in
// the same cycle it arrives. Push on full and pop on empty are ignored.
module lsu_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   // A depth of one still needs a 1-bit pointer; it simply never moves off 0.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit with pipelined, in-order bus responses.
// Request path (byte enables, lane-aligned store data, misalignment check)
// is combinational; a tracking FIFO remembers each accepted op so the
// matching response can be shifted and sign/zero-extended for writeback.
// Optional macro LSU_WB_REG_EN registers the writeback outputs (1-cycle
// latency after mem_rvalid_i); without it writeback is combinational.
module exu_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int RD_W            = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  lsu_op_t             req_op_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [RD_W-1:0]     req_rd_i,
   output logic                misaligned_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   input  logic                mem_gnt_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                wb_valid_o,
   output logic [RD_W-1:0]     wb_rd_o,
   output logic [DATA_W-1:0]   wb_data_o,
   output logic                busy_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [OFF_W-1:0]  w_off;
   logic [2:0]        w_off3;
   size_t             w_size;
   logic              w_is_load;
   logic              w_illegal;
   logic              w_misalign;
   logic              w_bad;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_pop;
   logic [CNT_W-1:0]  w_count;
   lsu_entry_t        w_push_entry;
   lsu_entry_t        w_head;
   logic [DATA_W-1:0] w_shifted;
   logic [DATA_W-1:0] w_lo_mask;
   logic              w_sign;
   logic [DATA_W-1:0] w_ext;
   logic              w_wb_valid;
   logic [RD_W-1:0]   w_wb_rd;
   logic [DATA_W-1:0] w_wb_data;

   // ---------------- request side ----------------
   assign w_off     = req_addr_i[OFF_W-1:0];
   assign w_off3    = 3'(w_off);
   assign w_size    = op_size(req_op_i);
   assign w_is_load = op_is_load(req_op_i);

   // Doubleword ops and LWU do not exist on a 32-bit datapath.
   assign w_illegal = ~op_is_known(req_op_i) |
                      ((DATA_W == 32) & ((w_size == SZ_D) | (req_op_i == OP_LWU)));

   // Offset must be a multiple of the access size.
   always_comb begin
      w_misalign = 1'b0;
      case (w_size)
         SZ_H:    w_misalign = w_off3[0];
         SZ_W:    w_misalign = |w_off3[1:0];
         SZ_D:    w_misalign = |w_off3;
         default: w_misalign = 1'b0;
      endcase
   end

   assign w_bad        = w_illegal | w_misalign;
   // A full tracker blocks new requests even when a response pops this cycle.
   assign mem_req_o    = req_valid_i & ~w_bad & ~w_full;
   assign w_accept     = mem_req_o & mem_gnt_i;
   // Bad ops are consumed immediately so dispatch can raise the exception.
   assign req_ready_o  = w_accept | (req_valid_i & w_bad);
   assign misaligned_o = req_valid_i & w_bad;
   assign mem_we_o     = mem_req_o & ~w_is_load;
   assign mem_addr_o   = req_addr_i;
   assign mem_be_o     = mem_req_o ? BE_W'(be_mask(w_size, w_off3)) : '0;
   assign mem_wdata_o  = req_wdata_i << {w_off, 3'b000};

   assign w_push_entry = '{
      is_load:   w_is_load,
      size:      w_size,
      is_signed: op_is_signed(req_op_i),
      off:       w_off3,
      rd:        LSU_RD_MAX_W'(req_rd_i)
   };

   // ---------------- response tracking ----------------
   assign w_pop = mem_rvalid_i & ~w_empty;

   lsu_fifo #(
      .WIDTH ($bits(lsu_entry_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign busy_o = (w_count != '0);

   // ---------------- load data alignment / extension ----------------
   assign w_shifted = mem_rdata_i >> {w_head.off, 3'b000};
   // A doubleword shift by DATA_W bits clears everything, giving an all-ones mask.
   assign w_lo_mask = ~({DATA_W{1'b1}} << (8 << w_head.size));

   // Pick the most significant bit of the loaded item for sign extension.
   always_comb begin
      w_sign = 1'b0;
      case (w_head.size)
         SZ_B:    w_sign = w_shifted[7];
         SZ_H:    w_sign = w_shifted[15];
         SZ_W:    w_sign = w_shifted[31];
         default: w_sign = w_shifted[DATA_W-1];
      endcase
   end

   assign w_ext = (w_shifted & w_lo_mask) |
                  ((w_head.is_signed & w_sign) ? ~w_lo_mask : '0);

   // Store responses retire silently; idle writeback fields read as zero.
   assign w_wb_valid = w_pop & w_head.is_load;
   assign w_wb_rd    = w_wb_valid ? RD_W'(w_head.rd) : '0;
   assign w_wb_data  = w_wb_valid ? w_ext : '0;

`ifdef LSU_WB_REG_EN
   logic              r_wb_valid;
   logic [RD_W-1:0]   r_wb_rd;
   logic [DATA_W-1:0] r_wb_data;

   // Writeback stage register: result appears one cycle after the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_valid <= w_wb_valid;
         r_wb_rd    <= w_wb_rd;
         r_wb_data  <= w_wb_data;
      end
   end

   assign wb_valid_o = r_wb_valid;
   assign wb_rd_o    = r_wb_rd;
   assign wb_data_o  = r_wb_data;
`else
   assign wb_valid_o = w_wb_valid;
   assign wb_rd_o    = w_wb_rd;
   assign wb_data_o  = w_wb_data;
`endif

endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu: a 32-bit and a 64-bit instance share one
// stimulus stream; a queue-based model predicts every output each cycle.
module tb_exu_lsu;
   import lsu_pkg::*;

`ifdef LSU_WB_REG_EN
   localparam int WB_LAT = 1;
`else
   localparam int WB_LAT = 0;
`endif
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid, gnt, rvalid;
   lsu_op_t     req_op;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, rdata;
   logic [4:0]  req_rd;

   logic        r32_ready, r32_mis, r32_req, r32_we, r32_wbv, r32_busy;
   logic [31:0] r32_addr, r32_wdata, r32_wbd;
   logic [3:0]  r32_be;
   logic [4:0]  r32_wbrd;
   logic        r64_ready, r64_mis, r64_req, r64_we, r64_wbv, r64_busy;
   logic [31:0] r64_addr;
   logic [63:0] r64_wdata, r64_wbd;
   logic [7:0]  r64_be;
   logic [4:0]  r64_wbrd;

   exu_lsu #(.DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(MAXO), .RD_W(5)) dut32 (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(r32_ready),
      .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata[31:0]),
      .req_rd_i(req_rd), .misaligned_o(r32_mis), .mem_req_o(r32_req), .mem_we_o(r32_we),
      .mem_gnt_i(gnt), .mem_addr_o(r32_addr), .mem_be_o(r32_be), .mem_wdata_o(r32_wdata),
      .mem_rvalid_i(rvalid), .mem_rdata_i(rdata[31:0]), .wb_valid_o(r32_wbv),
      .wb_rd_o(r32_wbrd), .wb_data_o(r32_wbd), .busy_o(r32_busy));

   exu_lsu #(.DATA_W(64), .ADDR_W(32), .MAX_OUTSTANDING(MAXO), .RD_W(5)) dut64 (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(r64_ready),
      .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_rd_i(req_rd), .misaligned_o(r64_mis), .mem_req_o(r64_req), .mem_we_o(r64_we),
      .mem_gnt_i(gnt), .mem_addr_o(r64_addr), .mem_be_o(r64_be), .mem_wdata_o(r64_wdata),
      .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .wb_valid_o(r64_wbv),
      .wb_rd_o(r64_wbrd), .wb_data_o(r64_wbd), .busy_o(r64_busy));

   // Uniform views of both instances, index 0 = 32-bit, 1 = 64-bit.
   logic        o_ready [2], o_mis [2], o_req [2], o_we [2], o_wbv [2], o_busy [2];
   logic [63:0] o_addr [2], o_be [2], o_wd [2], o_wbd [2], o_wbrd [2];
   assign o_ready[0] = r32_ready;  assign o_ready[1] = r64_ready;
   assign o_mis[0]   = r32_mis;    assign o_mis[1]   = r64_mis;
   assign o_req[0]   = r32_req;    assign o_req[1]   = r64_req;
   assign o_we[0]    = r32_we;     assign o_we[1]    = r64_we;
   assign o_wbv[0]   = r32_wbv;    assign o_wbv[1]   = r64_wbv;
   assign o_busy[0]  = r32_busy;   assign o_busy[1]  = r64_busy;
   assign o_addr[0]  = 64'(r32_addr);  assign o_addr[1] = 64'(r64_addr);
   assign o_be[0]    = 64'(r32_be);    assign o_be[1]   = 64'(r64_be);
   assign o_wd[0]    = 64'(r32_wdata); assign o_wd[1]   = r64_wdata;
   assign o_wbd[0]   = 64'(r32_wbd);   assign o_wbd[1]  = r64_wbd;
   assign o_wbrd[0]  = 64'(r32_wbrd);  assign o_wbrd[1] = 64'(r64_wbrd);

   typedef struct {
      bit         ld;
      int         sz;
      bit         sg;
      int         off;
      logic [4:0] rd;
   } ment_t;

   ment_t       q32[$];
   ment_t       q64[$];
   bit          pv [2];
   logic [63:0] pd [2];
   logic [4:0]  prd [2];
   logic [63:0] last_wbd [2];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int op_bytes(input lsu_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_LWU, OP_SW: return 4;
         default:              return 8;
      endcase
   endfunction

   function automatic bit op_ld(input lsu_op_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
   endfunction

   function automatic bit op_sg(input lsu_op_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LD};
   endfunction

   task automatic drv(input bit v, input lsu_op_t op, input logic [31:0] a,
                      input logic [63:0] wd, input logic [4:0] rd,
                      input bit g, input bit rv, input logic [63:0] rdat);
      req_valid = v; req_op = op; req_addr = a; req_wdata = wd; req_rd = rd;
      gnt = g; rvalid = rv; rdata = rdat;
   endtask

   task automatic idle();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 0, 64'h0);
   endtask

   task automatic clr_last();
      last_wbd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      last_wbd[1] = 64'hDEAD_BEEF_DEAD_BEEF;
   endtask

   // One clock: check every output against the model, then advance the model.
   task automatic step();
      bit          psh [2];
      bit          pp [2];
      ment_t       ne [2];
      bit          cv [2];
      logic [63:0] cd [2];
      logic [4:0]  crd [2];
      #1;
      for (int w = 0; w < 2; w++) begin
         int nb, sz, off, qs;
         bit bad, full, e_req, e_mis, e_v;
         logic [63:0] wm, m, val, e_d;
         logic [4:0] e_rd;
         ment_t h;
         string sfx;
         nb  = (w == 0) ? 4 : 8;
         sfx = (w == 0) ? "32" : "64";
         wm  = (w == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
         sz  = op_bytes(req_op);
         off = int'(req_addr % nb);
         bad = (off % sz != 0) || (nb == 4 && (sz == 8 || req_op == OP_LWU));
         qs  = (w == 0) ? q32.size() : q64.size();
         full  = (qs == MAXO);
         e_req = req_valid && !bad && !full;
         e_mis = req_valid && bad;
         chk({"mem_req", sfx}, 64'(o_req[w]), 64'(e_req));
         chk({"misaligned", sfx}, 64'(o_mis[w]), 64'(e_mis));
         chk({"req_ready", sfx}, 64'(o_ready[w]), 64'((e_req && gnt) || e_mis));
         chk({"mem_addr", sfx}, o_addr[w], 64'(req_addr));
         chk({"busy", sfx}, 64'(o_busy[w]), 64'(qs != 0));
         if (e_req) begin
            chk({"mem_be", sfx}, o_be[w], ((64'd1 << sz) - 64'd1) << off);
            chk({"mem_wdata", sfx}, o_wd[w], (req_wdata << (off * 8)) & wm);
            chk({"mem_we", sfx}, 64'(o_we[w]), 64'(!op_ld(req_op)));
         end
         pp[w]  = rvalid && (qs > 0);
         cv[w]  = 1'b0;
         cd[w]  = 64'h0;
         crd[w] = 5'd0;
         if (pp[w]) begin
            h = (w == 0) ? q32[0] : q64[0];
            if (h.ld) begin
               m   = (h.sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (h.sz * 8)) - 64'd1);
               val = (rdata >> (h.off * 8)) & m;
               if (h.sg && val[h.sz*8-1]) val = val | ~m;
               cv[w]  = 1'b1;
               cd[w]  = val & wm;
               crd[w] = h.rd;
            end
         end
         e_v  = (WB_LAT != 0) ? pv[w] : cv[w];
         e_d  = (WB_LAT != 0) ? pd[w] : cd[w];
         e_rd = (WB_LAT != 0) ? prd[w] : crd[w];
         chk({"wb_valid", sfx}, 64'(o_wbv[w]), 64'(e_v));
         if (o_wbv[w]) last_wbd[w] = o_wbd[w];
         if (e_v) begin
            chk({"wb_rd", sfx}, o_wbrd[w], 64'(e_rd));
            chk({"wb_data", sfx}, o_wbd[w], e_d);
         end
         psh[w] = e_req && gnt;
         ne[w]  = '{ld: op_ld(req_op), sz: sz, sg: op_sg(req_op), off: off, rd: req_rd};
      end
      @(posedge clk);
      for (int w = 0; w < 2; w++) begin
         if (w == 0) begin
            if (pp[w]) void'(q32.pop_front());
            if (psh[w]) q32.push_back(ne[w]);
         end else begin
            if (pp[w]) void'(q64.pop_front());
            if (psh[w]) q64.push_back(ne[w]);
         end
         pv[w]  = cv[w];
         pd[w]  = cd[w];
         prd[w] = crd[w];
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      idle();
      rst = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q32.delete();
      q64.delete();
      for (int w = 0; w < 2; w++) begin
         pv[w] = 1'b0; pd[w] = 64'h0; prd[w] = 5'd0;
      end
   endtask

   initial begin
      logic [31:0] a;
      int          nb;
      clr_last();
      do_reset(2);

      // Reset state
      #1;
      chk("rst_busy", 64'(r32_busy), 64'h0);
      chk("rst_wbv", 64'(r32_wbv), 64'h0);
      chk("rst_wbd", 64'(r32_wbd), 64'h0);
      chk("rst_wbrd", 64'(r32_wbrd), 64'h0);
      chk("rst_req", 64'(r32_req), 64'h0);
      step();

      // SB to 0x1003, then its response must not write back
      drv(1, OP_SB, 32'h1003, 64'hAB, 5'd0, 1, 0, 64'h0);
      #1;
      chk("sb_be", 64'(r32_be), 64'h8);
      chk("sb_wdata", 64'(r32_wdata), 64'hAB00_0000);
      step();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      idle(); step();

      // LB / LBU at 0x2001 with byte 0x80 in lane 1
      clr_last();
      drv(1, OP_LB, 32'h2001, 64'h0, 5'd5, 1, 0, 64'h0); step();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'h8000); step();
      idle(); step();
      chk("lb_wb32", last_wbd[0], 64'hFFFF_FF80);
      chk("lb_wb64", last_wbd[1], 64'hFFFF_FFFF_FFFF_FF80);
      clr_last();
      drv(1, OP_LBU, 32'h2001, 64'h0, 5'd6, 1, 0, 64'h0); step();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'h8000); step();
      idle(); step();
      chk("lbu_wb32", last_wbd[0], 64'h80);

      // Misaligned LW
      drv(1, OP_LW, 32'h3002, 64'h0, 5'd1, 1, 0, 64'h0);
      #1;
      chk("lw_mis", 64'(r32_mis), 64'h1);
      chk("lw_mis_ready", 64'(r32_ready), 64'h1);
      chk("lw_mis_req", 64'(r32_req), 64'h0);
      step();
      idle();
      #1;
      chk("lw_mis_busy", 64'(r32_busy), 64'h0);
      step();

      // Three LWs, grant held, responses three cycles after each grant
      drv(1, OP_LW, 32'h100, 64'h0, 5'd1, 1, 0, 64'h0); step();
      drv(1, OP_LW, 32'h104, 64'h0, 5'd2, 1, 0, 64'h0); step();
      drv(1, OP_LW, 32'h108, 64'h0, 5'd3, 1, 0, 64'h0);
      #1; chk("full_block", 64'(r32_req), 64'h0);
      step();
      drv(1, OP_LW, 32'h108, 64'h0, 5'd3, 1, 1, 64'hA1A1_A1A1_A1A1_A1A1);
      #1; chk("full_pop_block", 64'(r32_req), 64'h0);
      step();
      drv(1, OP_LW, 32'h108, 64'h0, 5'd3, 1, 1, 64'hB2B2_B2B2_B2B2_B2B2);
      #1; chk("unblock", 64'(r32_req), 64'h1);
      step();
      idle(); step();
      idle(); step();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'h0C0C_0C0C_0C0C_0C0C); step();
      idle(); step();

      // LD and LW on the 64-bit datapath
      clr_last();
      drv(1, OP_LD, 32'h8, 64'h0, 5'd7, 1, 0, 64'h0); step();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'h1122_3344_5566_7788); step();
      idle(); step();
      chk("ld64", last_wbd[1], 64'h1122_3344_5566_7788);
      clr_last();
      drv(1, OP_LW, 32'h4, 64'h0, 5'd8, 1, 0, 64'h0); step();
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'h1122_3344_5566_7788); step();
      idle(); step();
      chk("lw64", last_wbd[1], 64'h0000_0000_1122_3344);
      chk("lw32", last_wbd[0], 64'h5566_7788);

      // Reset with two loads outstanding, then a stray response
      drv(1, OP_LW, 32'h200, 64'h0, 5'd9, 1, 0, 64'h0); step();
      drv(1, OP_LW, 32'h204, 64'h0, 5'd10, 1, 0, 64'h0); step();
      idle();
      #1; chk("pre_rst_busy", 64'(r32_busy), 64'h1);
      do_reset(2);
      drv(0, OP_LB, 32'h0, 64'h0, 5'd0, 0, 1, 64'h1234_5678_9ABC_DEF0);
      #1;
      chk("stray_wbv", 64'(r32_wbv), 64'h0);
      chk("stray_busy", 64'(r32_busy), 64'h0);
      step();
      idle(); step();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         if (i % 250 == 249) do_reset(1);
         req_op    = lsu_op_t'($urandom_range(0, 10));
         nb        = op_bytes(req_op);
         a         = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & ~(32'(nb) - 32'd1);
         req_addr  = a;
         req_valid = ($urandom_range(0, 3) != 0);
         req_wdata = {$urandom, $urandom};
         req_rd    = 5'($urandom_range(0, 31));
         gnt       = ($urandom_range(0, 3) != 0);
         rvalid    = ($urandom_range(0, 2) == 0);
         rdata     = {$urandom, $urandom};
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
